uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/baud_gen.sv | 20 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings and default frame constants shared by the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/baud_gen.sv
// baud_gen: free-running oversample tick, one clock wide every BAUD_DIV clocks.
module baud_gen #(
    parameter int BAUD_DIV = 163
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int W = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(BAUD_DIV - 1);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else          cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, LSB first, mid-bit sampling.
// Optional even-parity checking and the parity_err port are enabled by UART_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT     = DEF_DBIT,
    parameter int SB_TICK  = DEF_SB_TICK,
    parameter int BAUD_DIV = 163
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done,
    output logic            frame_err
`ifdef UART_PARITY_EN
   ,output logic            parity_err
`endif
);

    localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;

    state_t          state, state_n;
    logic [3:0]      s_cnt, s_cnt_n;
    logic [NW-1:0]   n_cnt, n_cnt_n;
    logic [DBIT-1:0] shreg, shreg_n, dout_n;
    logic            done_n, ferr_n;
    logic [1:0]      sync;
    logic            rx_s, tick;
`ifdef UART_PARITY_EN
    logic            par_bit, par_n, perr_n;
`endif

    baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick)
    );

    // rx is asynchronous; only the second flop feeds the FSM
    assign rx_s = sync[1];

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) sync <= 2'b11;
        else          sync <= {sync[0], rx};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shreg     <= '0;
            dout      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            n_cnt     <= n_cnt_n;
            shreg     <= shreg_n;
            dout      <= dout_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
`ifdef UART_PARITY_EN
            par_bit    <= par_n;
            parity_err <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        shreg_n = shreg;
        dout_n  = dout;
        done_n  = 1'b0;
        ferr_n  = frame_err;
`ifdef UART_PARITY_EN
        par_n   = par_bit;
        perr_n  = parity_err;
`endif
        case (state)
            IDLE:
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            START:
                if (tick) begin
                    if (s_cnt == 4'd7) begin
                        // still low at mid start bit: real frame, otherwise a glitch
                        state_n = rx_s ? IDLE : DATA;
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                    end else
                        s_cnt_n = s_cnt + 4'd1;
                end
            DATA:
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[DBIT-1:1]};
                        if (n_cnt == NW'(DBIT - 1))
`ifdef UART_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        else
                            n_cnt_n = n_cnt + 1'b1;
                    end else
                        s_cnt_n = s_cnt + 4'd1;
                end
`ifdef UART_PARITY_EN
            PARITY:
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        s_cnt_n = '0;
                        par_n   = rx_s;
                        state_n = STOP;
                    end else
                        s_cnt_n = s_cnt + 4'd1;
                end
`endif
            STOP:
                if (tick) begin
                    if (s_cnt == 4'(SB_TICK - 1)) begin
                        s_cnt_n = '0;
                        dout_n  = shreg;
                        ferr_n  = ~rx_s;
`ifdef UART_PARITY_EN
                        perr_n  = ^shreg ^ par_bit;
`endif
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else
                        s_cnt_n = s_cnt + 4'd1;
                end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected results are queued at send time and
// compared by an independent monitor whenever rx_done pulses.
module tb_uart_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;
`ifdef UART_PARITY_EN
    logic       parity_err;
`endif

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_done = 1'b0;

    always #5 clock = ~clock;

    uart_rx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx        (rx),
        .dout      (dout),
        .rx_done   (rx_done),
        .frame_err (frame_err)
`ifdef UART_PARITY_EN
       ,.parity_err(parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_per(input logic v, input int n = 64);
        rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        q.push_back('{d: d, fe: ~stop, pe: ^d ^ par});
        bit_per(1'b0);
        for (int i = 0; i < 8; i++) bit_per(d[i]);
`ifdef UART_PARITY_EN
        bit_per(par);
`endif
        if (stop) bit_per(1'b1);
        else begin
            // short low stop bit so the trailing low is rejected as a glitch start
            bit_per(1'b0, 40);
            bit_per(1'b1, 24);
        end
    endtask

    always @(negedge clock) begin
        if (rx_done) begin
            check("rx_done single-cycle", {31'd0, prev_done}, 32'd0);
            check("rx_done has pending frame", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("dout", {24'd0, dout}, {24'd0, e.d});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
`ifdef UART_PARITY_EN
                check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
`endif
            end
        end
        prev_done = rx_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("reset dout", {24'd0, dout}, 32'd0);
        check("reset rx_done", {31'd0, rx_done}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        bit_per(1'b1);

        send(8'hA5, 1'b1, 1'b0);
        bit_per(1'b1);

        bit_per(1'b0, 20);
        bit_per(1'b1, 80);
        check("glitch dout held", {24'd0, dout}, 32'h000000A5);
        check("glitch state idle", {29'd0, dut.state}, 32'd0);

        send(8'h3C, 1'b0, 1'b0);
        bit_per(1'b1, 128);

        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        bit_per(1'b1);

        bit_per(1'b0);
        for (int i = 0; i < 4; i++) bit_per(i[0] ? 1'b0 : 1'b1);
        bit_per(1'b1, 32);
        reset_n = 1'b0;
        #1;
        check("mid-frame reset dout", {24'd0, dout}, 32'd0);
        check("mid-frame reset rx_done", {31'd0, rx_done}, 32'd0);
        check("mid-frame reset frame_err", {31'd0, frame_err}, 32'd0);
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        bit_per(1'b1, 200);

        send(8'h81, 1'b1, 1'b0);
        bit_per(1'b1);

`ifdef UART_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        bit_per(1'b1);
        send(8'h07, 1'b1, 1'b1);
        bit_per(1'b1);
`endif

        bit_per(1'b1);
        check("scoreboard drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
